noc_mesh_router: RTL and testbench

//  Parametrised 5-port (N,S,E,W,L) mesh router. Replaces the per-position corner/edge router variants.
//  One module serves any mesh tile; PORT_EN masks off the absent edge ports.

---
 rtl/noc_pkg.sv | 49 ++++
 rtl/noc_in_fifo.sv | 61 ++++++
 rtl/noc_mesh_router.sv | 140 ++++++++++++++
 tb/tb_noc_mesh_router.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router: port indices, flit field layout,
// XY route decode and the round-robin pick helper.
package noc_pkg;

  localparam int NPORTS = 5;

  localparam int N = 0;
  localparam int S = 1;
  localparam int E = 2;
  localparam int W = 3;
  localparam int L = 4;

  // Destination fields inside the low byte of every flit.
  localparam int DEST_X_HI = 7;
  localparam int DEST_X_LO = 4;
  localparam int DEST_Y_HI = 3;
  localparam int DEST_Y_LO = 0;

  typedef logic [2:0] port_idx_t;

  // Dimension-order routing: resolve X first, then Y, else deliver locally.
  function automatic port_idx_t xy_route(input logic [3:0] destx,
                                         input logic [3:0] desty,
                                         input logic [3:0] x,
                                         input logic [3:0] y);
    port_idx_t p;
    if (destx > x)      p = port_idx_t'(E);
    else if (destx < x) p = port_idx_t'(W);
    else if (desty > y) p = port_idx_t'(S);
    else if (desty < y) p = port_idx_t'(N);
    else                p = port_idx_t'(L);
    return p;
  endfunction

  // First requester at or after ptr, wrapping modulo NPORTS.
  function automatic port_idx_t rr_pick(input logic [NPORTS-1:0] req,
                                        input port_idx_t         ptr);
    port_idx_t pick;
    int        idx;
    pick = ptr;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (req[idx]) pick = port_idx_t'(idx);
    end
    return pick;
  endfunction

endpackage

// File: rtl/noc_in_fifo.sv
// Per-input circular flit buffer. A push while full is dropped unless a pop
// frees the slot in the same cycle; the head is read combinationally.
module noc_in_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [FLIT_W-1:0] data_i,
  input  logic              pop_i,
  output logic [FLIT_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              do_pop, do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy next-state; pointers wrap naturally at power-of-2 depth.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Flit storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/noc_mesh_router.sv
// 5-port XY mesh router: per-input FIFOs, per-output round-robin arbitration,
// credit-based flow control and registered outputs. PORT_EN removes edge ports.
module noc_mesh_router
  import noc_pkg::*;
#(
  parameter int         XCOORD  = 0,
  parameter int         YCOORD  = 0,
  parameter int         FLIT_W  = 16,
  parameter int         DEPTH   = 4,
  parameter int         CREDITS = 4,
  parameter logic [4:0] PORT_EN = 5'b11111
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NPORTS-1:0][FLIT_W-1:0]  in_data,
  input  logic [NPORTS-1:0]              in_valid,
  output logic [NPORTS-1:0]              in_credit_o,
  output logic [NPORTS-1:0][FLIT_W-1:0]  out_data,
  output logic [NPORTS-1:0]              out_valid,
  input  logic [NPORTS-1:0]              out_credit_i,
  output logic                           misroute_o
);

  localparam int CW = $clog2(CREDITS + 1);

  logic [NPORTS-1:0][FLIT_W-1:0] head;
  logic [NPORTS-1:0]             empty, full, push, pop;
  port_idx_t [NPORTS-1:0]        route;
  logic [NPORTS-1:0]             misr;
  logic [NPORTS-1:0][NPORTS-1:0] req;      // req[o][i]
  logic [NPORTS-1:0][NPORTS-1:0] gnt;      // gnt[o][i]
  logic [NPORTS-1:0]             gnt_vld;
  port_idx_t [NPORTS-1:0]        gnt_idx;
  logic [NPORTS-1:0]             cred_ret;

  port_idx_t [NPORTS-1:0]        rr_q, rr_d;
  logic [NPORTS-1:0][CW-1:0]     cred_q, cred_d;
  logic [NPORTS-1:0][FLIT_W-1:0] out_data_q, out_data_d;
  logic [NPORTS-1:0]             out_valid_q, out_valid_d;
  logic [NPORTS-1:0]             in_credit_q, in_credit_d;
  logic                          misroute_q, misroute_d;

  assign push     = in_valid & PORT_EN;
  assign cred_ret = out_credit_i & PORT_EN;

  for (genvar p = 0; p < NPORTS; p++) begin : g_in
    noc_in_fifo #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[p]),
      .data_i  (in_data[p]),
      .pop_i   (pop[p]),
      .head_o  (head[p]),
      .empty_o (empty[p]),
      .full_o  (full[p])
    );
  end

  // Route decode of every head; heads aimed at an absent port become misroutes.
  always_comb begin
    req  = '0;
    misr = '0;
    for (int i = 0; i < NPORTS; i++) begin
      route[i] = xy_route(head[i][DEST_X_HI:DEST_X_LO], head[i][DEST_Y_HI:DEST_Y_LO],
                          4'(XCOORD), 4'(YCOORD));
      if (!empty[i] && PORT_EN[i]) begin
        if (PORT_EN[route[i]]) req[route[i]][i] = 1'b1;
        else                   misr[i]          = 1'b1;
      end
    end
  end

  // Round-robin grant per output, gated by credit; pointer moves only on a grant.
  always_comb begin
    gnt     = '0;
    gnt_vld = '0;
    rr_d    = rr_q;
    pop     = misr;
    for (int o = 0; o < NPORTS; o++) begin
      gnt_idx[o] = rr_pick(req[o], rr_q[o]);
      if ((|req[o]) && (cred_q[o] != '0)) begin
        gnt_vld[o]             = 1'b1;
        gnt[o][gnt_idx[o]]     = 1'b1;
        rr_d[o] = (gnt_idx[o] == port_idx_t'(NPORTS - 1)) ? '0 : gnt_idx[o] + 3'd1;
      end
    end
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (gnt[o][i]) pop[i] = 1'b1;
      end
    end
  end

  // Credit counters and output register next-state.
  always_comb begin
    cred_d      = cred_q;
    out_data_d  = out_data_q;
    out_valid_d = gnt_vld;
    in_credit_d = pop;
    misroute_d  = |misr;
    for (int o = 0; o < NPORTS; o++) begin
      if (gnt_vld[o] && !cred_ret[o])
        cred_d[o] = cred_q[o] - CW'(1);
      else if (!gnt_vld[o] && cred_ret[o] && (cred_q[o] != CW'(CREDITS)))
        cred_d[o] = cred_q[o] + CW'(1);
      if (gnt_vld[o]) out_data_d[o] = head[gnt_idx[o]];
    end
  end

  // State and output registers; protocol violations flagged in simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q        <= '0;
      for (int o = 0; o < NPORTS; o++) cred_q[o] <= CW'(CREDITS);
      out_data_q  <= '0;
      out_valid_q <= '0;
      in_credit_q <= '0;
      misroute_q  <= 1'b0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        assert (!(push[p] && full[p] && !pop[p]))
          else $error("noc_mesh_router: write to full input FIFO %0d", p);
        assert (!(cred_ret[p] && !gnt_vld[p] && (cred_q[p] == CW'(CREDITS))))
          else $error("noc_mesh_router: credit overflow on output %0d", p);
      end
      rr_q        <= rr_d;
      cred_q      <= cred_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_credit_q <= in_credit_d;
      misroute_q  <= misroute_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign in_credit_o = in_credit_q;
  assign misroute_o  = misroute_q;

endmodule

// File: tb/tb_noc_mesh_router.sv
// Directed bench: tile (1,1) fully enabled, plus an edge tile (0,1) with
// PORT_EN=10110 for misroute and disabled-port behaviour.
module tb_noc_mesh_router;
  import noc_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0][15:0] in_data  = '0, in_data2  = '0;
  logic [4:0]       in_valid = '0, in_valid2 = '0;
  logic [4:0]       out_credit = '0, out_credit2 = '0;
  logic [4:0]       auto_ret = '0;
  logic [4:0]       in_credit, in_credit2, out_valid, out_valid2;
  logic [4:0][15:0] out_data, out_data2;
  logic             misroute, misroute2;

  int n_assert = 0;
  int n_fail   = 0;
  int emitted;
  int src_tab [3] = '{0, 1, 3};

  always #5 clk = ~clk;

  noc_mesh_router #(.XCOORD(1), .YCOORD(1), .FLIT_W(16), .DEPTH(4), .CREDITS(4),
                    .PORT_EN(5'b11111)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_credit_o(in_credit), .out_data(out_data), .out_valid(out_valid),
    .out_credit_i(out_credit), .misroute_o(misroute));

  noc_mesh_router #(.XCOORD(0), .YCOORD(1), .FLIT_W(16), .DEPTH(4), .CREDITS(4),
                    .PORT_EN(5'b10110)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2),
    .in_credit_o(in_credit2), .out_data(out_data2), .out_valid(out_valid2),
    .out_credit_i(out_credit2), .misroute_o(misroute2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1ns later, and return credits for outputs in auto_ret.
  task automatic tick;
    @(posedge clk);
    #1;
    out_credit = out_valid & auto_ret;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = '0; in_valid2 = '0; out_credit = '0; auto_ret = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [15:0] mkf(input int src, input int seq, input int dx, input int dy);
    return {4'(src), 4'(seq), 4'(dx), 4'(dy)};
  endfunction

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data_E", 32'(out_data[E]), 32'h0);
    chk("rst_in_credit", 32'(in_credit), 32'h0);
    chk("rst_misroute", 32'(misroute), 32'h0);
    chk("rst_out_valid2", 32'(out_valid2), 32'h0);
    rst = 1'b0;

    // T1: L -> E, two-cycle latency, credit pulse alongside
    in_data[L] = 16'hAB21; in_valid[L] = 1'b1;
    tick;
    in_valid = '0;
    chk("t1_not_yet", 32'(out_valid), 32'h0);
    tick;
    chk("t1_valid_E", 32'(out_valid), 32'h04);
    chk("t1_data_E", 32'(out_data[E]), 32'hAB21);
    chk("t1_credit_L", 32'(in_credit), 32'h10);
    tick;
    chk("t1_valid_drop", 32'(out_valid), 32'h0);
    chk("t1_credit_drop", 32'(in_credit), 32'h0);
    chk("t1_data_hold", 32'(out_data[E]), 32'hAB21);

    // T2: N,S,W contend for L; grants rotate N,S,W
    do_reset;
    auto_ret = 5'b10000;
    for (int r = 0; r < 6; r++) begin
      in_valid = 5'b01011;
      in_data[N] = mkf(0, r, 1, 1);
      in_data[S] = mkf(1, r, 1, 1);
      in_data[W] = mkf(3, r, 1, 1);
      tick;
      in_valid = '0;
      for (int k = 0; k < 3; k++) begin
        tick;
        chk("t2_valid_L", 32'(out_valid), 32'h10);
        chk("t2_data_L", 32'(out_data[L]), 32'(mkf(src_tab[k], r, 1, 1)));
        chk("t2_in_credit", 32'(in_credit), 32'(5'b1 << src_tab[k]));
      end
    end

    // T3: credit exhaustion on E, then one returned credit releases one flit
    do_reset;
    emitted = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid[L] = 1'b1; in_data[L] = mkf(4, k, 2, 1);
      tick;
      if (out_valid[E]) begin
        chk("t3_order", 32'(out_data[E]), 32'(mkf(4, emitted, 2, 1)));
        emitted++;
      end
    end
    in_valid = '0;
    repeat (3) begin
      tick;
      if (out_valid[E]) begin
        chk("t3_order", 32'(out_data[E]), 32'(mkf(4, emitted, 2, 1)));
        emitted++;
      end
    end
    chk("t3_credit_limit", 32'(emitted), 32'd4);
    chk("t3_stalled", 32'(out_valid), 32'h0);
    out_credit[E] = 1'b1;
    tick;
    chk("t3_ret_lat", 32'(out_valid), 32'h0);
    tick;
    chk("t3_one_more", 32'(out_valid), 32'h04);
    chk("t3_one_more_data", 32'(out_data[E]), 32'(mkf(4, 4, 2, 1)));
    tick;
    chk("t3_only_one", 32'(out_valid), 32'h0);

    // T4: edge tile, flit for absent N port is dropped; disabled input ignored
    do_reset;
    in_valid2[S] = 1'b1; in_data2[S] = mkf(5, 0, 0, 0);
    tick;
    in_valid2 = '0;
    chk("t4_mis_early", 32'(misroute2), 32'h0);
    tick;
    chk("t4_misroute", 32'(misroute2), 32'h1);
    chk("t4_credit_S", 32'(in_credit2), 32'h02);
    chk("t4_no_out", 32'(out_valid2), 32'h0);
    tick;
    chk("t4_mis_pulse", 32'(misroute2), 32'h0);
    chk("t4_credit_pulse", 32'(in_credit2), 32'h0);
    in_valid2[N] = 1'b1; in_data2[N] = mkf(6, 0, 0, 1);
    tick;
    in_valid2 = '0;
    tick; tick;
    chk("t4_dis_in_out", 32'(out_valid2), 32'h0);
    chk("t4_dis_in_cred", 32'(in_credit2), 32'h0);
    in_valid2[S] = 1'b1; in_data2[S] = mkf(7, 0, 0, 1);
    tick;
    in_valid2 = '0;
    tick;
    chk("t4_local_valid", 32'(out_valid2), 32'h10);
    chk("t4_local_data", 32'(out_data2[L]), 32'(mkf(7, 0, 0, 1)));

    // T5: full FIFO S with E blocked, push+pop same cycle, order across wrap
    do_reset;
    for (int k = 0; k < 4; k++) begin
      in_valid[L] = 1'b1; in_data[L] = mkf(4, k, 2, 1);
      tick;
    end
    in_valid = '0;
    repeat (3) tick;
    for (int k = 0; k < 4; k++) begin
      in_valid[S] = 1'b1; in_data[S] = mkf(1, k, 2, 1);
      tick;
    end
    in_valid = '0;
    tick; tick;
    chk("t5_blocked", 32'(out_valid), 32'h0);
    out_credit[E] = 1'b1;
    tick;
    in_valid[S] = 1'b1; in_data[S] = mkf(1, 4, 2, 1);
    tick;
    in_valid = '0;
    chk("t5_pp_valid", 32'(out_valid), 32'h04);
    chk("t5_pp_data", 32'(out_data[E]), 32'(mkf(1, 0, 2, 1)));
    chk("t5_pp_credit", 32'(in_credit), 32'h02);
    auto_ret = 5'b00100;
    out_credit[E] = 1'b1;
    emitted = 1;
    repeat (12) begin
      tick;
      if (out_valid[E]) begin
        chk("t5_order", 32'(out_data[E]), 32'(mkf(1, emitted, 2, 1)));
        emitted++;
      end
    end
    chk("t5_total", 32'(emitted), 32'd5);

    // T6: reset while flits are buffered and an output is valid
    do_reset;
    for (int b = 0; b < 2; b++) begin
      in_valid = 5'b01011;
      in_data[N] = mkf(0, b, 1, 1);
      in_data[S] = mkf(1, b, 1, 1);
      in_data[W] = mkf(3, b, 1, 1);
      tick;
    end
    in_valid = '0;
    chk("t6_pre_valid", 32'(out_valid), 32'h10);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'h0);
    chk("t6_rst_data", 32'(out_data[L]), 32'h0);
    chk("t6_rst_credit", 32'(in_credit), 32'h0);
    chk("t6_rst_mis", 32'(misroute), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick; tick;
    chk("t6_flushed", 32'(out_valid), 32'h0);
    emitted = 0;
    for (int k = 0; k < 5; k++) begin
      in_valid[L] = 1'b1; in_data[L] = mkf(4, k, 1, 1);
      tick;
      if (out_valid[L]) begin
        chk("t6_post_order", 32'(out_data[L]), 32'(mkf(4, emitted, 1, 1)));
        emitted++;
      end
    end
    in_valid = '0;
    repeat (3) begin
      tick;
      if (out_valid[L]) begin
        chk("t6_post_order", 32'(out_data[L]), 32'(mkf(4, emitted, 1, 1)));
        emitted++;
      end
    end
    chk("t6_credits_reset", 32'(emitted), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
